// File: rtl/rtc_shadow_bank.sv
// rtc_shadow_bank
//   Translates RTC addresses from two contiguous register windows (A and B)
//   into a dense local index. Keeps a shadow copy of every mapped register,
//   tracks which entries the user has modified, and runs a scan sequencer.
//   The sequencer either refreshes the shadows from the RTC or writes the
//   dirty entries back to it.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   dec_addr/dec_idx/     combinational address-to-index lookup
//   dec_valid
//   usr_we/usr_widx/      user write port (sets the dirty flag)
//   usr_wdata
//   usr_ridx/usr_rdata    user read port, 1-cycle registered latency
//   dirty                 per-entry modified flags
//   scan_start/scan_mode  start a scan: 0 = refresh, 1 = write back dirty
//   scan_req/scan_addr/   RTC transaction request, held until scan_ack
//   scan_wdata
//   scan_ack/scan_rdata   RTC transaction completion and read data
//   scan_busy             sequencer not idle
//   scan_done/scan_err    one-cycle completion / timeout-abort pulses
module rtc_shadow_bank #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int IDX_W   = 4,
  parameter int BASE_A  = 'h21,
  parameter int COUNT_A = 7,
  parameter int BASE_B  = 'h41,
  parameter int COUNT_B = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          dec_addr,
  output logic [IDX_W-1:0]           dec_idx,
  output logic                       dec_valid,
  input  logic                       usr_we,
  input  logic [IDX_W-1:0]           usr_widx,
  input  logic [DATA_W-1:0]          usr_wdata,
  input  logic [IDX_W-1:0]           usr_ridx,
  output logic [DATA_W-1:0]          usr_rdata,
  output logic [COUNT_A+COUNT_B-1:0] dirty,
  input  logic                       scan_start,
  input  logic                       scan_mode,
  output logic                       scan_req,
  output logic [ADDR_W-1:0]          scan_addr,
  output logic [DATA_W-1:0]          scan_wdata,
  input  logic                       scan_ack,
  input  logic [DATA_W-1:0]          scan_rdata,
  output logic                       scan_busy,
  output logic                       scan_done,
  output logic                       scan_err
);

  localparam int TOTAL = COUNT_A + COUNT_B;
  localparam int PTR_W = $clog2(TOTAL + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W:0]   A_LO      = (ADDR_W+1)'(BASE_A);
  localparam logic [ADDR_W:0]   A_HI      = (ADDR_W+1)'(BASE_A + COUNT_A);
  localparam logic [ADDR_W:0]   B_LO      = (ADDR_W+1)'(BASE_B);
  localparam logic [ADDR_W:0]   B_HI      = (ADDR_W+1)'(BASE_B + COUNT_B);
  localparam logic [IDX_W-1:0]  IDX_INV   = '1;
  localparam logic [IDX_W-1:0]  IDX_CNT_A = IDX_W'(COUNT_A);
  localparam logic [IDX_W-1:0]  IDX_TOTAL = IDX_W'(TOTAL);
  localparam logic [PTR_W-1:0]  PTR_TOTAL = PTR_W'(TOTAL);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(TOTAL - 1);
  localparam logic [PTR_W-1:0]  PTR_CNT_A = PTR_W'(COUNT_A);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  // The all-ones index is the "invalid" marker, so it can never be a real entry.
  if (TOTAL > (2 ** IDX_W) - 1) begin : g_chk_total
    $error("rtc_shadow_bank: COUNT_A+COUNT_B does not fit below the reserved index");
  end
  if (!((BASE_A + COUNT_A <= BASE_B) || (BASE_B + COUNT_B <= BASE_A))) begin : g_chk_overlap
    $error("rtc_shadow_bank: address windows A and B overlap");
  end
  if (TIMEOUT < 1) begin : g_chk_tmo
    $error("rtc_shadow_bank: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_REQ, S_DONE} state_t;

  function automatic logic [ADDR_W-1:0] idx_to_addr(input logic [PTR_W-1:0] i);
    if (i < PTR_CNT_A) return ADDR_W'(BASE_A) + ADDR_W'(i);
    return ADDR_W'(BASE_B) + ADDR_W'(i - PTR_CNT_A);
  endfunction

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                mode_q, mode_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DATA_W-1:0]   shadow_q [TOTAL];
  logic [DATA_W-1:0]   shadow_d [TOTAL];
  logic [TOTAL-1:0]    dirty_q, dirty_d;
  logic [DATA_W-1:0]   usr_rdata_q, usr_rdata_d;
  logic                scan_req_q, scan_req_d;
  logic [ADDR_W-1:0]   scan_addr_q, scan_addr_d;
  logic [DATA_W-1:0]   scan_wdata_q, scan_wdata_d;
  logic                scan_done_q, scan_done_d;
  logic                scan_err_q, scan_err_d;
  logic [ADDR_W:0]     dec_ext;

  // Address decode; widened by one bit so window ends at the top of the
  // address space cannot wrap.
  always_comb begin
    dec_ext   = {1'b0, dec_addr};
    dec_idx   = IDX_INV;
    dec_valid = 1'b0;
    if (!reset) begin
      if (dec_ext >= A_LO && dec_ext < A_HI) begin
        dec_idx   = IDX_W'(dec_ext - A_LO);
        dec_valid = 1'b1;
      end else if (dec_ext >= B_LO && dec_ext < B_HI) begin
        dec_idx   = IDX_CNT_A + IDX_W'(dec_ext - B_LO);
        dec_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    mode_d       = mode_q;
    tmo_d        = tmo_q;
    shadow_d     = shadow_q;
    dirty_d      = dirty_q;
    scan_req_d   = scan_req_q;
    scan_addr_d  = scan_addr_q;
    scan_wdata_d = scan_wdata_q;
    scan_done_d  = 1'b0;
    scan_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          ptr_d   = '0;
          mode_d  = scan_mode;
          state_d = S_SEEK;
        end
      end
      S_SEEK: begin
        if (ptr_q == PTR_TOTAL) begin
          state_d     = S_DONE;
          scan_done_d = 1'b1;
        end else if (mode_q && !dirty_q[ptr_q]) begin
          // Clean entry in write-back mode: skip it. Finishing straight from
          // the last entry keeps an all-clean scan at exactly TOTAL cycles.
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == PTR_LAST) begin
            state_d     = S_DONE;
            scan_done_d = 1'b1;
          end
        end else begin
          scan_addr_d  = idx_to_addr(ptr_q);
          scan_wdata_d = shadow_q[ptr_q];
          tmo_d        = '0;
          scan_req_d   = 1'b1;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (scan_ack) begin
          // A refresh never overwrites an entry the user has modified.
          if (!mode_q) begin
            if (!dirty_q[ptr_q]) shadow_d[ptr_q] = scan_rdata;
          end else begin
            dirty_d[ptr_q] = 1'b0;
          end
          ptr_d      = ptr_q + 1'b1;
          scan_req_d = 1'b0;
          state_d    = S_SEEK;
        end else if (tmo_q == TMO_LAST) begin
          scan_req_d = 1'b0;
          scan_err_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // User write is applied last so it wins over a same-cycle scan update.
    if (usr_we && usr_widx < IDX_TOTAL) begin
      shadow_d[usr_widx] = usr_wdata;
      dirty_d[usr_widx]  = 1'b1;
    end

    // Reads see the pre-edge shadow, so a same-cycle write returns old data.
    usr_rdata_d = (usr_ridx < IDX_TOTAL) ? shadow_q[usr_ridx] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      mode_q       <= 1'b0;
      tmo_q        <= '0;
      shadow_q     <= '{default: '0};
      dirty_q      <= '0;
      usr_rdata_q  <= '0;
      scan_req_q   <= 1'b0;
      scan_addr_q  <= ADDR_W'(BASE_A);
      scan_wdata_q <= '0;
      scan_done_q  <= 1'b0;
      scan_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      mode_q       <= mode_d;
      tmo_q        <= tmo_d;
      shadow_q     <= shadow_d;
      dirty_q      <= dirty_d;
      usr_rdata_q  <= usr_rdata_d;
      scan_req_q   <= scan_req_d;
      scan_addr_q  <= scan_addr_d;
      scan_wdata_q <= scan_wdata_d;
      scan_done_q  <= scan_done_d;
      scan_err_q   <= scan_err_d;
    end
  end

  assign usr_rdata  = usr_rdata_q;
  assign dirty      = dirty_q;
  assign scan_req   = scan_req_q;
  assign scan_addr  = scan_addr_q;
  assign scan_wdata = scan_wdata_q;
  assign scan_done  = scan_done_q;
  assign scan_err   = scan_err_q;
  assign scan_busy  = (state_q != S_IDLE);

endmodule
